wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage directly upstream of the integer register file. Merges ALU results and
//  in-order load responses into one registered write port (en/addr/data) feeding the regfile.
//  Tracks outstanding loads in a small FIFO, formats load data (align + sign/zero extend) and
//  exports a per-register busy scoreboard to decode for load-use stalls.
// PARAMETERS
//  XLEN     64  register/data width (matches REG_WIDTH)
//  LD_MAX   2   max outstanding loads (FIFO depth, power of 2, >=2)
// PORTS
//  clk              in   1     clock, all state on posedge
//  rst              in   1     synchronous reset, active-high
//  alu_valid_in     in   1     ALU result valid
//  alu_ready_out    out  1     stage accepts ALU result this cycle
//  alu_wen_in       in   1     ALU instr writes rd
//  alu_rd_in        in   5     ALU destination
//  alu_data_in      in   XLEN  ALU result
//  ld_issue_in      in   1     load dispatched to LSU this cycle
//  ld_issue_rd_in   in   5     load destination
//  ld_issue_f3_in   in   3     load funct3
//  ld_issue_off_in  in   3     byte offset addr[2:0]
//  ld_full_out      out  1     LD_MAX loads outstanding; decode must not issue
//  ld_rsp_valid_in  in   1     load data returned (in issue order, no backpressure)
//  ld_rsp_data_in   in   XLEN  raw aligned-doubleword data
//  busy_out         out  32    busy[r]=1: load to r pending, r not yet written
//  ld_err_out       out  1     sticky: response with empty FIFO or issue while full
//  reg_wr_en_out    out  1     to regfile write enable
//  reg_wr_addr_out  out  5     to regfile write address
//  reg_wr_data_out  out  XLEN  to regfile write data
// BEHAVIOUR
//  - Reset: FIFO emptied, busy_out=0, ld_err_out=0, reg_wr_*_out=0, ld_full_out=0; in-flight
//    loads are discarded (late responses after reset set ld_err_out).
//  - Output register: reg_wr_* updated every edge; latency 1 cycle from accept to regfile
//    capture edge (+1 edge). reg_wr_en_out=0 in any cycle nothing is accepted.
//  - Arbitration: ld_rsp_valid_in has absolute priority. alu_ready_out = !ld_rsp_valid_in.
//    ALU accepted when alu_valid_in & alu_ready_out; writes only if alu_wen_in.
//  - rd==0: never produces reg_wr_en_out=1, never sets busy; FIFO entry still allocated.
//  - Load FIFO: issue pushes {rd,f3,off}; response pops head. Push+pop same cycle legal, count
//    unchanged. Issue while full: dropped, ld_err_out=1. Response while empty: ignored, err=1.
//  - Load format: d = ld_rsp_data_in >> (8*off). f3 000 lb / 100 lbu: d[7:0] sign/zero ext;
//    001 lh / 101 lhu: d[15:0]; 010 lw / 110 lwu: d[31:0]; 011 ld: d; 111: raw data, err=1.
//    Misaligned offsets are not checked; upper bits shifted in are zero before extension.
//  - Scoreboard: busy[rd] set on the edge accepting ld_issue_in (rd!=0). Cleared on the edge
//    where reg_wr_en_out=1 for that load (same edge the regfile captures), but only if no
//    remaining FIFO entry targets the same rd. Set and clear of same r in one edge: set wins.
//  - ALU writes never touch busy; WAW/RAW against pending loads is decode's responsibility.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: adds output retire_cnt_out [63:0], reset 0, +1 per accepted ALU
//    result or load response (incl. rd==0, excl. error-ignored responses), wraps at 2^64-1.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 ALU valid rd=5 data=0x1234, no load -> cycle+1 reg_wr_en=1 addr=5 data=0x1234; ready=1.
//  2 Issue lb rd=7 off=3, rsp data=0x0000_0000_8000_0000 -> busy[7]=1 until write;
//    write data=0xFFFF_FFFF_FFFF_FF80; busy[7]=0 edge after that cycle.
//  3 ALU valid + ld_rsp same cycle -> alu_ready_out=0, load written first; ALU held, written
//    next cycle.
//  4 Two issues rd=9 (lw,lhu) then two rsps -> busy[9] stays 1 after first write, clears after
//    second; ld_full_out=1 while 2 outstanding; third issue while full -> ld_err_out=1.
//  5 ALU rd=0 data=0xDEAD and load rd=0 -> reg_wr_en_out stays 0, busy_out stays 0.
//  6 Assert rst with 1 load pending -> busy/FIFO/outputs 0; then rsp -> ignored, ld_err_out=1.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: merges ALU results and in-order load responses into one registered regfile write port.
// Latency: 1 edge from accept to reg_wr_*; load responses win, so ALU sees alu_ready_out=0 while one returns.
// Optional WB_RETIRE_CNT_EN adds retire_cnt_out, a count of retired results.
module wb_stage #(
  parameter int XLEN   = 64,
  parameter int LD_MAX = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid_in,
  output logic            alu_ready_out,
  input  logic            alu_wen_in,
  input  logic [4:0]      alu_rd_in,
  input  logic [XLEN-1:0] alu_data_in,
  input  logic            ld_issue_in,
  input  logic [4:0]      ld_issue_rd_in,
  input  logic [2:0]      ld_issue_f3_in,
  input  logic [2:0]      ld_issue_off_in,
  output logic            ld_full_out,
  input  logic            ld_rsp_valid_in,
  input  logic [XLEN-1:0] ld_rsp_data_in,
  output logic [31:0]     busy_out,
  output logic            ld_err_out,
  output logic            reg_wr_en_out,
  output logic [4:0]      reg_wr_addr_out,
  output logic [XLEN-1:0] reg_wr_data_out
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt_out
`endif
);

  localparam int PW = $clog2(LD_MAX);
  localparam int CW = PW + 1;

  logic [4:0]      fifo_rd  [LD_MAX];
  logic [2:0]      fifo_f3  [LD_MAX];
  logic [2:0]      fifo_off [LD_MAX];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            wr_is_ld;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            bad_issue;
  logic            bad_rsp;
  logic            alu_acc;
  logic [4:0]      head_rd;
  logic [2:0]      head_f3;
  logic [2:0]      head_off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ld_data;
  logic            ld_fmt_err;
  logic            nxt_en;
  logic [4:0]      nxt_addr;
  logic [XLEN-1:0] nxt_data;
  logic            nxt_is_ld;
  logic [PW-1:0]   rel;
  logic            still_pending;
  logic [31:0]     busy_nxt;

  assign full          = (count == CW'(LD_MAX));
  assign empty         = (count == '0);
  assign push          = ld_issue_in && !full;
  assign bad_issue     = ld_issue_in && full;
  assign pop           = ld_rsp_valid_in && !empty;
  assign bad_rsp       = ld_rsp_valid_in && empty;
  assign alu_ready_out = !ld_rsp_valid_in;
  assign alu_acc       = alu_valid_in && alu_ready_out;
  assign ld_full_out   = full;
  assign head_rd       = fifo_rd[rd_ptr];
  assign head_f3       = fifo_f3[rd_ptr];
  assign head_off      = fifo_off[rd_ptr];

  // Shifted-in upper bits are zero, so extension only ever sees the selected field.
  always_comb begin
    shifted    = ld_rsp_data_in >> {head_off, 3'b000};
    ld_data    = ld_rsp_data_in;
    ld_fmt_err = 1'b0;
    case (head_f3)
      3'b000:  ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  ld_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b011:  ld_data = shifted;
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  ld_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: begin
        ld_data    = ld_rsp_data_in;
        ld_fmt_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    nxt_en    = 1'b0;
    nxt_addr  = '0;
    nxt_data  = '0;
    nxt_is_ld = 1'b0;
    if (pop) begin
      nxt_en    = (head_rd != 5'd0);
      nxt_addr  = head_rd;
      nxt_data  = ld_data;
      nxt_is_ld = 1'b1;
    end else if (alu_acc) begin
      nxt_en   = alu_wen_in && (alu_rd_in != 5'd0);
      nxt_addr = alu_rd_in;
      nxt_data = alu_data_in;
    end
  end

  // A retiring load keeps its rd busy if a younger load still in the FIFO targets it.
  always_comb begin
    still_pending = 1'b0;
    rel           = '0;
    for (int i = 0; i < LD_MAX; i++) begin
      rel = PW'(i) - rd_ptr;
      if (({1'b0, rel} < count) && (fifo_rd[i] == reg_wr_addr_out))
        still_pending = 1'b1;
    end
    busy_nxt = busy_out;
    if (wr_is_ld && reg_wr_en_out && !still_pending)
      busy_nxt[reg_wr_addr_out] = 1'b0;
    if (push && (ld_issue_rd_in != 5'd0))
      busy_nxt[ld_issue_rd_in] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]  <= ld_issue_rd_in;
      fifo_f3[wr_ptr]  <= ld_issue_f3_in;
      fifo_off[wr_ptr] <= ld_issue_off_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      busy_out        <= '0;
      ld_err_out      <= 1'b0;
      reg_wr_en_out   <= 1'b0;
      reg_wr_addr_out <= '0;
      reg_wr_data_out <= '0;
      wr_is_ld        <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      busy_out <= busy_nxt;
      if (bad_issue || bad_rsp || (pop && ld_fmt_err))
        ld_err_out <= 1'b1;
      reg_wr_en_out   <= nxt_en;
      reg_wr_addr_out <= nxt_addr;
      reg_wr_data_out <= nxt_data;
      wr_is_ld        <= nxt_is_ld;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      retire_cnt_out <= '0;
    else if (pop || alu_acc)
      retire_cnt_out <= retire_cnt_out + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the writeback stage.
`timescale 1ns/1ps
module tb_wb_stage;
  localparam int XLEN   = 64;
  localparam int LD_MAX = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        alu_valid;
  logic        alu_wen;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_issue;
  logic [4:0]  iss_rd;
  logic [2:0]  iss_f3;
  logic [2:0]  iss_off;
  logic        rsp_valid;
  logic [63:0] rsp_data;

  logic        alu_ready_out;
  logic        ld_full_out;
  logic [31:0] busy_out;
  logic        ld_err_out;
  logic        reg_wr_en_out;
  logic [4:0]  reg_wr_addr_out;
  logic [63:0] reg_wr_data_out;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  wb_stage #(.XLEN(XLEN), .LD_MAX(LD_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_in(alu_valid), .alu_ready_out(alu_ready_out), .alu_wen_in(alu_wen),
    .alu_rd_in(alu_rd), .alu_data_in(alu_data),
    .ld_issue_in(ld_issue), .ld_issue_rd_in(iss_rd), .ld_issue_f3_in(iss_f3),
    .ld_issue_off_in(iss_off), .ld_full_out(ld_full_out),
    .ld_rsp_valid_in(rsp_valid), .ld_rsp_data_in(rsp_data),
    .busy_out(busy_out), .ld_err_out(ld_err_out),
    .reg_wr_en_out(reg_wr_en_out), .reg_wr_addr_out(reg_wr_addr_out),
    .reg_wr_data_out(reg_wr_data_out)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt_out(retire_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [2:0] off;
  } ld_ent_t;

  ld_ent_t     q[$];
  logic        m_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  logic        m_is_ld = 1'b0;
  logic        m_err = 1'b0;
  logic [63:0] m_cnt = '0;
  logic        alu_acc_last = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] fmt(input ld_ent_t e, input logic [63:0] raw);
    logic [63:0] d;
    d = raw >> (8 * e.off);
    case (e.f3)
      3'd0:    return 64'($signed(d[7:0]));
      3'd1:    return 64'($signed(d[15:0]));
      3'd2:    return 64'($signed(d[31:0]));
      3'd3:    return d;
      3'd4:    return 64'(d[7:0]);
      3'd5:    return 64'(d[15:0]);
      3'd6:    return 64'(d[31:0]);
      default: return raw;
    endcase
  endfunction

  // Busy = some queued load targets r, or the write now on the port is a load to r.
  task automatic compare();
    logic [31:0] eb;
    eb = '0;
    foreach (q[i]) if (q[i].rd != 5'd0) eb[q[i].rd] = 1'b1;
    if (m_en && m_is_ld) eb[m_addr] = 1'b1;
    chk("wr_en", 64'(reg_wr_en_out), 64'(m_en));
    if (m_en) begin
      chk("wr_addr", 64'(reg_wr_addr_out), 64'(m_addr));
      chk("wr_data", reg_wr_data_out, m_data);
    end
    chk("busy", 64'(busy_out), 64'(eb));
    chk("full", 64'(ld_full_out), 64'(q.size() == LD_MAX));
    chk("err", 64'(ld_err_out), 64'(m_err));
    chk("alu_ready", 64'(alu_ready_out), 64'(!rsp_valid));
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, m_cnt);
`endif
  endtask

  task automatic model_edge();
    bit      was_full;
    ld_ent_t e;
    if (rst) begin
      q.delete();
      m_en = 1'b0; m_addr = '0; m_data = '0; m_is_ld = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else begin
      was_full = (q.size() == LD_MAX);
      m_en = 1'b0;
      m_is_ld = 1'b0;
      if (rsp_valid) begin
        if (q.size() == 0) m_err = 1'b1;
        else begin
          e = q.pop_front();
          m_en = (e.rd != 5'd0); m_addr = e.rd; m_data = fmt(e, rsp_data); m_is_ld = 1'b1;
          if (e.f3 == 3'd7) m_err = 1'b1;
          m_cnt++;
        end
      end else if (alu_valid) begin
        m_en = alu_wen && (alu_rd != 5'd0); m_addr = alu_rd; m_data = alu_data;
        m_cnt++;
      end
      if (ld_issue) begin
        if (was_full) m_err = 1'b1;
        else q.push_back('{iss_rd, iss_f3, iss_off});
      end
    end
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    #1;
    compare();
    alu_acc_last = alu_valid && !rsp_valid;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; alu_valid = 1'b0; alu_wen = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; iss_rd = '0; iss_f3 = '0; iss_off = '0; rsp_valid = 1'b0; rsp_data = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off);
    idle(); ld_issue = 1'b1; iss_rd = rd; iss_f3 = f3; iss_off = off;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_en", 64'(reg_wr_en_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_err", 64'(ld_err_out), 64'd0);
    chk("rst_full", 64'(ld_full_out), 64'd0);
    rst = 1'b0;

    // 1: plain ALU write
    idle(); alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    #1 chk("t1_ready", 64'(alu_ready_out), 64'd1);
    tick();
    chk("t1_en", 64'(reg_wr_en_out), 64'd1);
    chk("t1_addr", 64'(reg_wr_addr_out), 64'd5);
    chk("t1_data", reg_wr_data_out, 64'h1234);

    // 2: lb at offset 3, busy held until the regfile capture edge
    issue(5'd7, 3'd0, 3'd3); tick();
    chk("t2_busy_set", 64'(busy_out[7]), 64'd1);
    idle(); rsp_valid = 1'b1; rsp_data = 64'h0000_0000_8000_0000; tick();
    chk("t2_data", reg_wr_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    chk("t2_busy_during", 64'(busy_out[7]), 64'd1);
    idle(); tick();
    chk("t2_busy_clr", 64'(busy_out[7]), 64'd0);

    // 3: load response beats a waiting ALU result
    issue(5'd3, 3'd2, 3'd0); tick();
    idle(); alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd4; alu_data = 64'h55;
    rsp_valid = 1'b1; rsp_data = 64'h1_FFFF_FFFF;
    #1 chk("t3_ready_lo", 64'(alu_ready_out), 64'd0);
    tick();
    chk("t3_ld_addr", 64'(reg_wr_addr_out), 64'd3);
    chk("t3_ld_data", reg_wr_data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    rsp_valid = 1'b0;
    tick();
    chk("t3_alu_addr", 64'(reg_wr_addr_out), 64'd4);
    chk("t3_alu_data", reg_wr_data_out, 64'h55);

    // 4: two loads to rd=9, full, then overflow issue
    issue(5'd9, 3'd2, 3'd0); tick();
    issue(5'd9, 3'd5, 3'd2); tick();
    chk("t4_full", 64'(ld_full_out), 64'd1);
    issue(5'd10, 3'd0, 3'd0); tick();
    chk("t4_err", 64'(ld_err_out), 64'd1);
    chk("t4_no_busy10", 64'(busy_out[10]), 64'd0);
    idle(); rsp_valid = 1'b1; rsp_data = 64'h0000_0000_ABCD_8765; tick();
    chk("t4_lw", reg_wr_data_out, 64'hFFFF_FFFF_ABCD_8765);
    tick();
    chk("t4_lhu", reg_wr_data_out, 64'h0000_0000_0000_ABCD);
    chk("t4_busy_kept", 64'(busy_out[9]), 64'd1);
    idle(); tick();
    chk("t4_busy_clr", 64'(busy_out[9]), 64'd0);
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_err_rst", 64'(ld_err_out), 64'd0);

    // 5: rd=0 never writes or sets busy
    idle(); alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD; tick();
    chk("t5_alu_en", 64'(reg_wr_en_out), 64'd0);
    issue(5'd0, 3'd3, 3'd0); tick();
    chk("t5_busy", 64'(busy_out), 64'd0);
    idle(); rsp_valid = 1'b1; rsp_data = 64'h77; tick();
    chk("t5_ld_en", 64'(reg_wr_en_out), 64'd0);

    // 6: reset with a load pending, then a late response
    issue(5'd12, 3'd3, 3'd0); tick();
    chk("t6_busy", 64'(busy_out[12]), 64'd1);
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_busy_rst", 64'(busy_out), 64'd0);
    chk("t6_full_rst", 64'(ld_full_out), 64'd0);
    chk("t6_err_rst", 64'(ld_err_out), 64'd0);
    idle(); rsp_valid = 1'b1; rsp_data = 64'h1; tick();
    chk("t6_late_err", 64'(ld_err_out), 64'd1);
    chk("t6_late_en", 64'(reg_wr_en_out), 64'd0);
    idle(); rst = 1'b1; tick(); rst = 1'b0;

    // Legal random traffic: no error should ever be raised.
    idle();
    for (int c = 0; c < 600; c++) begin
      if (!(alu_valid && !alu_acc_last)) begin
        alu_valid = ($urandom % 2) == 0;
        alu_wen   = ($urandom % 4) != 0;
        alu_rd    = 5'($urandom);
        alu_data  = {$urandom, $urandom};
      end
      rsp_valid = (q.size() > 0) && (($urandom % 3) == 0);
      rsp_data  = {$urandom, $urandom};
      ld_issue  = (q.size() < LD_MAX) && (($urandom % 3) == 0);
      iss_rd    = 5'($urandom % 8);
      iss_f3    = 3'($urandom % 7);
      iss_off   = 3'($urandom);
      tick();
    end

    // Unconstrained traffic with occasional resets and protocol errors.
    for (int c = 0; c < 600; c++) begin
      if (!(alu_valid && !alu_acc_last)) begin
        alu_valid = ($urandom % 2) == 0;
        alu_wen   = ($urandom % 4) != 0;
        alu_rd    = 5'($urandom);
        alu_data  = {$urandom, $urandom};
      end
      rst       = ($urandom % 40) == 0;
      rsp_valid = ($urandom % 3) == 0;
      rsp_data  = {$urandom, $urandom};
      ld_issue  = ($urandom % 2) == 0;
      iss_rd    = 5'($urandom % 8);
      iss_f3    = 3'($urandom);
      iss_off   = 3'($urandom);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
